// File: rtl/wt_pkg.sv
// Shared definitions for the wavetable record path: table width, recorder
// states and the preset tables the note block falls back to.
package wt_pkg;

    localparam int unsigned WT_BITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } rec_state_t;

    localparam int unsigned N_PRESETS     = 4;
    localparam logic [31:0] PRESET_SQUARE = 32'hFFFF_0000;
    localparam logic [31:0] PRESET_PULSE  = 32'hFF00_0000;
    localparam logic [31:0] PRESET_ALT    = 32'hAAAA_AAAA;
    localparam logic [31:0] PRESET_NOISE  = 32'h9B3C_5E71;

    function automatic logic [31:0] preset_table(input logic [1:0] sel);
        logic [31:0] tbl;
        case (sel)
            2'd0:    tbl = PRESET_SQUARE;
            2'd1:    tbl = PRESET_PULSE;
            2'd2:    tbl = PRESET_ALT;
            2'd3:    tbl = PRESET_NOISE;
            default: tbl = PRESET_SQUARE;
        endcase
        return tbl;
    endfunction

endpackage

// File: rtl/wavetable_recorder_btn_debounce.sv
// Two-flop synchroniser plus stability counter for a bouncy pushbutton.
// level follows raw only after it has disagreed for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Stability counter: any agreeing cycle restarts the count
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser and debounce state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/wavetable_recorder.sv
// Records a 1-bit user-played wavetable MSB first at one sample per CLK_DIV
// cycles and publishes it atomically to the note block with a select flag.
module wavetable_recorder
    import wt_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 25000,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned WT_BITS         = WT_BITS_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               RecBtn,
    input  logic               ClrBtn,
    input  logic               SampleIn,
    output logic [WT_BITS-1:0] Rec_WT,
    output logic               Record,
    output logic               Busy,
    output logic               Done
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned BW = $clog2(WT_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(WT_BITS - 1);

    rec_state_t         state_q;
    rec_state_t         state_d;
    logic               clr_s1_q;
    logic               clr_s2_q;
    logic               smp_s1_q;
    logic               smp_s2_q;
    logic [DW-1:0]      div_q;
    logic [DW-1:0]      div_d;
    logic [BW-1:0]      bitcnt_q;
    logic [BW-1:0]      bitcnt_d;
    logic [WT_BITS-1:0] shift_q;
    logic [WT_BITS-1:0] shift_d;
    logic [WT_BITS-1:0] rec_wt_q;
    logic [WT_BITS-1:0] rec_wt_d;
    logic               record_q;
    logic               record_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;
    logic               rec_level_s;
    logic               rec_rise_s;
    logic               rec_edge_s;
    logic               tick_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rec_debounce (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (RecBtn),
        .level (rec_level_s),
        .rise  (rec_rise_s)
    );

    assign rec_edge_s = rec_rise_s & rec_level_s;
    assign tick_s     = (state_q == CAPTURE) && (div_q == DIV_LAST);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear beats a record edge, a second edge aborts
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clr_s2_q) begin
                    state_d = IDLE;
                end else if (rec_edge_s) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (clr_s2_q || rec_edge_s) begin
                    state_d = IDLE;
                end else if (tick_s && (bitcnt_q == BITS_LAST)) begin
                    state_d = DONE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture datapath: divider, bit counter and shift register
    always_comb begin
        shift_d  = shift_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        if ((state_q == IDLE) && (state_d == CAPTURE)) begin
            shift_d  = '0;
            div_d    = '0;
            bitcnt_d = '0;
        end else if (state_q == CAPTURE) begin
            if (tick_s) begin
                div_d    = '0;
                shift_d  = {shift_q[WT_BITS-2:0], smp_s2_q};
                bitcnt_d = bitcnt_q + BW'(1);
            end else begin
                div_d = div_q + DW'(1);
            end
        end else begin
            div_d = div_q;
        end
    end

    // Output logic: Rec_WT only ever loads a complete table
    always_comb begin
        rec_wt_d = rec_wt_q;
        record_d = record_q;
        busy_d   = (state_d == CAPTURE);
        done_d   = (state_q == DONE);
        if (clr_s2_q) begin
            record_d = 1'b0;
        end else if (state_q == DONE) begin
            rec_wt_d = shift_q;
            record_d = 1'b1;
        end else begin
            record_d = record_q;
        end
    end

    // Synchronisers, datapath and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            smp_s1_q <= 1'b0;
            smp_s2_q <= 1'b0;
            div_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            rec_wt_q <= '0;
            record_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            clr_s1_q <= ClrBtn;
            clr_s2_q <= clr_s1_q;
            smp_s1_q <= SampleIn;
            smp_s2_q <= smp_s1_q;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            rec_wt_q <= rec_wt_d;
            record_q <= record_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Rec_WT = rec_wt_q;
    assign Record = record_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_wavetable_recorder.sv
// Directed bench for wavetable_recorder: completed captures are queued as
// expectations and a monitor compares them whenever Done pulses.
module tb_wavetable_recorder;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned WT       = 32;
    localparam int          LATENCY  = 129;

    typedef struct {
        logic [31:0] wt;
        logic        rec;
        int          lat;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          RecBtn = 1'b0;
    logic          ClrBtn = 1'b0;
    logic          SampleIn = 1'b0;
    logic [WT-1:0] Rec_WT;
    logic          Record;
    logic          Busy;
    logic          Done;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_rise_cyc = 0;
    logic busy_prev = 1'b0;

    wavetable_recorder #(
        .CLK_DIV         (CLK_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .WT_BITS         (WT)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RecBtn   (RecBtn),
        .ClrBtn   (ClrBtn),
        .SampleIn (SampleIn),
        .Rec_WT   (Rec_WT),
        .Record   (Record),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: timestamps Busy rising and scores every Done pulse
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (Busy && !busy_prev) busy_rise_cyc = cyc;
            busy_prev = Busy;
            if (Done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got Done=1 expected no Done (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("done_rec_wt", Rec_WT, e.wt);
                    check("done_record", {31'd0, Record}, {31'd0, e.rec});
                    check("done_latency", cyc - busy_rise_cyc, e.lat);
                end
            end
        end else begin
            busy_prev = 1'b0;
        end
    end

    // Press RecBtn and hold it until Busy is seen (bounded)
    task automatic start_capture(output bit ok);
        ok = 1'b0;
        RecBtn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Busy) begin
                ok = 1'b1;
                break;
            end
        end
        RecBtn = 1'b0;
        check("busy_rise", {31'd0, ok}, 32'd1);
    endtask

    // One bit per tick, MSB first, each held across its sampling edge
    task automatic drive_samples(input logic [31:0] val, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            SampleIn = val[31-k];
            repeat (CLK_DIV) @(negedge CLK);
        end
        SampleIn = 1'b0;
    endtask

    initial begin
        bit   ok;
        logic busy_seen;

        // 1: reset and idle
        repeat (3) @(negedge CLK);
        check("rst_rec_wt", Rec_WT, 32'h0);
        check("rst_record", {31'd0, Record}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        RST_N = 1'b1;
        repeat (50) @(negedge CLK);
        check("idle_rec_wt", Rec_WT, 32'h0);
        check("idle_record", {31'd0, Record}, 32'd0);
        check("idle_busy", {31'd0, Busy}, 32'd0);

        // 2: full capture of 0xF0F0A5A5
        start_capture(ok);
        exp_q.push_back('{32'hF0F0A5A5, 1'b1, LATENCY});
        drive_samples(32'hF0F0A5A5, 32);
        repeat (6) @(negedge CLK);
        check("cap1_pending", exp_q.size(), 32'd0);
        check("cap1_rec_wt", Rec_WT, 32'hF0F0A5A5);
        check("cap1_record", {31'd0, Record}, 32'd1);
        check("cap1_busy", {31'd0, Busy}, 32'd0);

        // 3: short glitches never reach the debounced level
        busy_seen = 1'b0;
        for (int g = 0; g < 5; g++) begin
            RecBtn = 1'b1;
            repeat (2) begin @(negedge CLK); busy_seen |= Busy; end
            RecBtn = 1'b0;
            @(negedge CLK); busy_seen |= Busy;
        end
        repeat (10) begin @(negedge CLK); busy_seen |= Busy; end
        check("glitch_busy", {31'd0, busy_seen}, 32'd0);
        check("glitch_rec_wt", Rec_WT, 32'hF0F0A5A5);

        // 4: second press after 10 ticks aborts the capture
        start_capture(ok);
        drive_samples(32'h0F0F_0F0F, 10);
        check("abort_busy_before", {31'd0, Busy}, 32'd1);
        RecBtn = 1'b1;
        repeat (8) @(negedge CLK);
        RecBtn = 1'b0;
        repeat (10) @(negedge CLK);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_rec_wt", Rec_WT, 32'hF0F0A5A5);
        check("abort_record", {31'd0, Record}, 32'd1);

        // 5: clear in idle, then clear coinciding with a record edge
        ClrBtn = 1'b1;
        @(negedge CLK);
        ClrBtn = 1'b0;
        repeat (5) @(negedge CLK);
        check("clr_record", {31'd0, Record}, 32'd0);
        check("clr_rec_wt", Rec_WT, 32'hF0F0A5A5);
        busy_seen = 1'b0;
        RecBtn = 1'b1;
        ClrBtn = 1'b1;
        repeat (10) begin @(negedge CLK); busy_seen |= Busy; end
        RecBtn = 1'b0;
        ClrBtn = 1'b0;
        repeat (10) begin @(negedge CLK); busy_seen |= Busy; end
        check("clr_rec_busy", {31'd0, busy_seen}, 32'd0);
        check("clr_rec_record", {31'd0, Record}, 32'd0);

        // 6: asynchronous reset at tick 20, then a clean capture
        start_capture(ok);
        drive_samples(32'hFFFF_FFFF, 20);
        check("pre_rst_busy", {31'd0, Busy}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_rec_wt", Rec_WT, 32'h0);
        check("arst_record", {31'd0, Record}, 32'd0);
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_done", {31'd0, Done}, 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        start_capture(ok);
        exp_q.push_back('{32'h13577EC8, 1'b1, LATENCY});
        drive_samples(32'h13577EC8, 32);
        repeat (6) @(negedge CLK);
        check("cap2_pending", exp_q.size(), 32'd0);
        check("cap2_rec_wt", Rec_WT, 32'h13577EC8);
        check("cap2_record", {31'd0, Record}, 32'd1);
        check("cap2_busy", {31'd0, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
